conv_mem_host: RTL and testbench
================================

# conv_mem_host

Synthesizable host-side responder for the CONV engine: owns the grayscale image store and the five layer-result banks, drives the `ready`/`busy` start handshake, answers image fetches (`iaddr`/`idata`) and layer memory reads/writes (`crd`/`cwr`/`csel`). It sits between the system loader and CONV, replacing the behavioural memory models in hardware-in-loop and FPGA builds. A readback port lets the host drain results once CONV drops `busy`.

## Interface
- `DW`, 20: data width (signed 4.16 fixed point, opaque here)
- `IMG_DEPTH`, 4096: image store words
- `L0_DEPTH`, 4096: depth of banks csel=1,2
- `L1_DEPTH`, 1024: depth of banks csel=3,4
- `L2_DEPTH`, 2048: depth of bank csel=5

- `clk` in 1: sole clock, all logic on rising edge
- `reset` in 1: asynchronous, active-low
- `img_we` in 1: host image write strobe (accepted in IDLE only)
- `img_addr` in 12, `img_wdata` in DW: host image write address/data
- `start` in 1: one-cycle pulse, begins a run (IDLE only)
- `ready` out 1: to CONV
- `busy` in 1: from CONV
- `iaddr` in 12, `idata` out DW: image fetch
- `cwr` in 1, `caddr_wr` in 12, `cdata_wr` in DW: layer write
- `crd` in 1, `caddr_rd` in 12, `cdata_rd` out DW: layer read
- `csel` in 3: bank select, 1..5 valid
- `rb_sel` in 3, `rb_addr` in 12, `rb_data` out DW: host readback
- `done` out 1: one-cycle pulse at run end
- `err` out 2: sticky; bit0 invalid csel, bit1 address out of range

## Operation
- FSM: IDLE, RDY, RUN, FIN.
- IDLE: `ready`=0; `img_we` writes image; `start` -> RDY (start ignored elsewhere).
- RDY: `ready`=1; on sampled `busy`=1 -> RUN.
- RUN: `ready`=0; `idata`/`crd`/`cwr` serviced; on sampled `busy` 1->0 -> FIN.
- FIN: `done`=1 for one cycle -> IDLE.
- Image fetch: `idata` registered, = image[`iaddr` sampled at edge k] after edge k; outside RUN `idata`=0.
- Layer write: `cwr`=1 at edge -> bank[`csel`][`caddr_wr`] <= `cdata_wr`. Active in RUN only.
- Layer read: `crd`=1 at edge -> `cdata_rd` <= bank[`csel`][`caddr_rd`]; `crd`=0 holds `cdata_rd`.
- Same-cycle `cwr` and `crd` to same bank/address: read returns old data (read-before-write).
- `csel` 0,6,7 with `cwr` or `crd`: write dropped, read loads 0, `err[0]` set.
- Readback: `rb_data` <= bank[`rb_sel`][`rb_addr`] each edge in IDLE; in other states `rb_data` holds. rb_sel 0 reads image store.
- `err` cleared only by reset or `start`.

## Timing
- Reset: state IDLE, `ready`=0, `idata`=0, `cdata_rd`=0, `rb_data`=0, `done`=0, `err`=0. Memory contents not reset.
- `start` at edge k -> `ready`=1 after edge k.
- `busy`=1 sampled at edge m -> `ready`=0 after edge m.
- Read latency 1 cycle for `idata`, `cdata_rd`, `rb_data`.
- `busy` falling sampled at edge n -> `done`=1 after edge n+1, IDLE after edge n+2.
- `busy` never rising: remains in RDY indefinitely; reset is the only exit.
- Reset mid-run: immediate IDLE, `ready` low asynchronously; stored data retained.

## Configuration
- `CMEM_BOUNDS_CHK_EN` defined: write/read address >= bank depth -> write dropped, read loads 0, `err[1]` set. Applies to L1/L2 banks and image store.
- Undefined: address taken modulo bank depth (low bits only); `err[1]` tied 0.

## Test plan
- Reset mid-RDY: pulse start, assert `reset`=0 -> `ready`=0 same cycle, `done` never pulses, `err`=0.
- Handshake: start at k, `busy`=1 at k+3 -> `ready` high k+1..k+3, low after k+3; drop `busy` at k+20 -> `done` one cycle after k+21.
- Image fetch: load image[i]=i*3, run, sweep `iaddr` 0..4095 -> `idata`=iaddr*3 one cycle later.
- Banks: write 0x12345 to csel=1 addr 7 and 0xABCDE to csel=2 addr 7, read both -> distinct values; readback after done matches.
- Collision: bank 3 addr 10 holds 0x00001; same-cycle `cwr` 0x00002 and `crd` -> `cdata_rd`=0x00001, next read 0x00002.
- Errors: `cwr` with csel=6 -> `err[0]`=1, no bank changed; csel=3 addr 1024 -> with macro `err[1]`=1 and addr 0 untouched; without macro addr 0 overwritten.

Source files
------------

// File: rtl/conv_mem_host.sv
// conv_mem_host: host-side memory responder for the CONV engine.
//
// Owns the grayscale image store and five layer-result banks. It runs the
// ready/busy start handshake with CONV, serves image fetches and layer bank
// reads/writes while CONV runs, and lets the host load the image and read
// results back while idle.
//
// Optional feature: define CMEM_BOUNDS_CHK_EN to reject addresses at or beyond
// a bank's depth. A rejected write is dropped, a rejected read returns 0, and
// err[1] is set. With the macro undefined, addresses wrap to the bank depth by
// using only the low bits, and err[1] stays 0.
//
// Ports:
//   clk, reset               clock; asynchronous active-low reset
//   img_we/img_addr/img_wdata host image write (IDLE only)
//   start                    one-cycle run request (IDLE only)
//   ready / busy             handshake to / from CONV
//   iaddr / idata            image fetch, 1-cycle latency, 0 outside RUN
//   cwr/caddr_wr/cdata_wr    layer write (RUN only)
//   crd/caddr_rd/cdata_rd    layer read (RUN only), cdata_rd holds when crd=0
//   csel                     layer bank select, 1..5 valid
//   rb_sel/rb_addr/rb_data   host readback (IDLE only), rb_sel=0 is the image
//   done                     one-cycle pulse at end of run
//   err                      sticky: bit0 bad csel, bit1 address out of range
module conv_mem_host #(
    parameter int unsigned DW        = 20,
    parameter int unsigned IMG_DEPTH = 4096,
    parameter int unsigned L0_DEPTH  = 4096,
    parameter int unsigned L1_DEPTH  = 1024,
    parameter int unsigned L2_DEPTH  = 2048
) (
    input  logic          clk,
    input  logic          reset,
    input  logic          img_we,
    input  logic [11:0]   img_addr,
    input  logic [DW-1:0] img_wdata,
    input  logic          start,
    output logic          ready,
    input  logic          busy,
    input  logic [11:0]   iaddr,
    output logic [DW-1:0] idata,
    input  logic          cwr,
    input  logic [11:0]   caddr_wr,
    input  logic [DW-1:0] cdata_wr,
    input  logic          crd,
    input  logic [11:0]   caddr_rd,
    output logic [DW-1:0] cdata_rd,
    input  logic [2:0]    csel,
    input  logic [2:0]    rb_sel,
    input  logic [11:0]   rb_addr,
    output logic [DW-1:0] rb_data,
    output logic          done,
    output logic [1:0]    err
);

    localparam int unsigned IMG_AW = $clog2(IMG_DEPTH);
    localparam int unsigned L0_AW  = $clog2(L0_DEPTH);
    localparam int unsigned L1_AW  = $clog2(L1_DEPTH);
    localparam int unsigned L2_AW  = $clog2(L2_DEPTH);

    typedef enum logic [1:0] {
        StIdle,
        StRdy,
        StRun,
        StFin
    } state_e;

    state_e        state_q, state_d;
    logic          busy_q;
    logic [DW-1:0] idata_q, idata_d;
    logic [DW-1:0] cdata_q, cdata_d;
    logic [DW-1:0] rb_q, rb_d;
    logic [1:0]    err_q, err_d;

    // Storage; contents are deliberately not reset.
    logic [DW-1:0] img_mem [IMG_DEPTH];
    logic [DW-1:0] l0a_mem [L0_DEPTH];
    logic [DW-1:0] l0b_mem [L0_DEPTH];
    logic [DW-1:0] l1a_mem [L1_DEPTH];
    logic [DW-1:0] l1b_mem [L1_DEPTH];
    logic [DW-1:0] l2_mem  [L2_DEPTH];

`ifdef CMEM_BOUNDS_CHK_EN
    // Selector 0 is the image store; 6/7 never flag here (caught by sel_ok).
    function automatic logic addr_oob(input logic [2:0] sel, input logic [11:0] addr);
        int unsigned depth;
        case (sel)
            3'd0:       depth = IMG_DEPTH;
            3'd1, 3'd2: depth = L0_DEPTH;
            3'd3, 3'd4: depth = L1_DEPTH;
            3'd5:       depth = L2_DEPTH;
            default:    depth = 32'd4096;
        endcase
        return {20'd0, addr} >= depth;
    endfunction
`endif

    // Shared read mux: 0 = image, 1..5 = layer banks, 6/7 read as zero.
    function automatic logic [DW-1:0] mem_read(input logic [2:0] sel, input logic [11:0] addr);
        logic [DW-1:0] word;
        word = '0;
        case (sel)
            3'd0:    word = img_mem[addr[IMG_AW-1:0]];
            3'd1:    word = l0a_mem[addr[L0_AW-1:0]];
            3'd2:    word = l0b_mem[addr[L0_AW-1:0]];
            3'd3:    word = l1a_mem[addr[L1_AW-1:0]];
            3'd4:    word = l1b_mem[addr[L1_AW-1:0]];
            3'd5:    word = l2_mem[addr[L2_AW-1:0]];
            default: word = '0;
        endcase
`ifdef CMEM_BOUNDS_CHK_EN
        if (addr_oob(sel, addr)) begin
            word = '0;
        end
`endif
        return word;
    endfunction

    logic in_idle, in_run;
    logic sel_ok;
    logic wr_oob, rd_oob, img_wr_oob, img_rd_oob;
    logic img_wr_en, lyr_wr_en, lyr_rd_en;

    assign in_idle = (state_q == StIdle);
    assign in_run  = (state_q == StRun);
    assign sel_ok  = (csel >= 3'd1) && (csel <= 3'd5);

`ifdef CMEM_BOUNDS_CHK_EN
    assign wr_oob     = addr_oob(csel, caddr_wr);
    assign rd_oob     = addr_oob(csel, caddr_rd);
    assign img_wr_oob = addr_oob(3'd0, img_addr);
    assign img_rd_oob = addr_oob(3'd0, iaddr);
`else
    assign wr_oob     = 1'b0;
    assign rd_oob     = 1'b0;
    assign img_wr_oob = 1'b0;
    assign img_rd_oob = 1'b0;
`endif

    assign img_wr_en = in_idle && img_we && !img_wr_oob;
    assign lyr_wr_en = in_run && cwr && sel_ok && !wr_oob;
    assign lyr_rd_en = in_run && crd;

    // Memory writes. Reads elsewhere see pre-edge contents, which gives
    // read-before-write on a same-cycle collision.
    always_ff @(posedge clk) begin
        if (img_wr_en) begin
            img_mem[img_addr[IMG_AW-1:0]] <= img_wdata;
        end
        if (lyr_wr_en) begin
            case (csel)
                3'd1:    l0a_mem[caddr_wr[L0_AW-1:0]] <= cdata_wr;
                3'd2:    l0b_mem[caddr_wr[L0_AW-1:0]] <= cdata_wr;
                3'd3:    l1a_mem[caddr_wr[L1_AW-1:0]] <= cdata_wr;
                3'd4:    l1b_mem[caddr_wr[L1_AW-1:0]] <= cdata_wr;
                3'd5:    l2_mem[caddr_wr[L2_AW-1:0]]  <= cdata_wr;
                default: ;
            endcase
        end
    end

    always_comb begin
        state_d = state_q;
        err_d   = err_q;
        idata_d = '0;
        cdata_d = cdata_q;
        rb_d    = rb_q;

        unique case (state_q)
            StIdle: begin
                if (start) begin
                    state_d = StRdy;
                    err_d   = '0;
                end
            end
            StRdy: begin
                if (busy) begin
                    state_d = StRun;
                end
            end
            StRun: begin
                // busy_q is 1 on entry, so a 0 here is a sampled 1->0 fall.
                if (!busy_q) begin
                    state_d = StFin;
                end
            end
            StFin: begin
                state_d = StIdle;
            end
            default: begin
                state_d = StIdle;
            end
        endcase

        // Loading on the next state keeps idata zero whenever not in RUN.
        if (state_d == StRun) begin
            idata_d = mem_read(3'd0, iaddr);
        end

        if (lyr_rd_en) begin
            cdata_d = sel_ok ? mem_read(csel, caddr_rd) : '0;
        end

        if (in_idle) begin
            rb_d = mem_read(rb_sel, rb_addr);
        end

        if (in_run && (cwr || crd) && !sel_ok) begin
            err_d[0] = 1'b1;
        end
        if (in_run && sel_ok && ((cwr && wr_oob) || (crd && rd_oob))) begin
            err_d[1] = 1'b1;
        end
        if ((in_idle && img_we && img_wr_oob) || (in_run && img_rd_oob)) begin
            err_d[1] = 1'b1;
        end
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_q <= StIdle;
            busy_q  <= 1'b0;
            idata_q <= '0;
            cdata_q <= '0;
            rb_q    <= '0;
            err_q   <= '0;
        end else begin
            state_q <= state_d;
            busy_q  <= busy;
            idata_q <= idata_d;
            cdata_q <= cdata_d;
            rb_q    <= rb_d;
            err_q   <= err_d;
        end
    end

    // Decoded from the state register so reset drops ready immediately.
    assign ready    = (state_q == StRdy);
    assign done     = (state_q == StFin);
    assign idata    = idata_q;
    assign cdata_rd = cdata_q;
    assign rb_data  = rb_q;
    assign err      = err_q;

endmodule

// File: tb/tb_conv_mem_host.sv
// tb_conv_mem_host: randomized self-checking bench for conv_mem_host.
// A behavioural store model (one array per selector) predicts every read.
module tb_conv_mem_host;

    logic        clk = 1'b0;
    logic        reset = 1'b0;
    logic        img_we = 1'b0;
    logic [11:0] img_addr = '0;
    logic [19:0] img_wdata = '0;
    logic        start = 1'b0;
    logic        ready;
    logic        busy = 1'b0;
    logic [11:0] iaddr = '0;
    logic [19:0] idata;
    logic        cwr = 1'b0;
    logic [11:0] caddr_wr = '0;
    logic [19:0] cdata_wr = '0;
    logic        crd = 1'b0;
    logic [11:0] caddr_rd = '0;
    logic [19:0] cdata_rd;
    logic [2:0]  csel = '0;
    logic [2:0]  rb_sel = '0;
    logic [11:0] rb_addr = '0;
    logic [19:0] rb_data;
    logic        done;
    logic [1:0]  err;

    conv_mem_host dut (
        .clk       (clk),
        .reset     (reset),
        .img_we    (img_we),
        .img_addr  (img_addr),
        .img_wdata (img_wdata),
        .start     (start),
        .ready     (ready),
        .busy      (busy),
        .iaddr     (iaddr),
        .idata     (idata),
        .cwr       (cwr),
        .caddr_wr  (caddr_wr),
        .cdata_wr  (cdata_wr),
        .crd       (crd),
        .caddr_rd  (caddr_rd),
        .cdata_rd  (cdata_rd),
        .csel      (csel),
        .rb_sel    (rb_sel),
        .rb_addr   (rb_addr),
        .rb_data   (rb_data),
        .done      (done),
        .err       (err)
    );

    always #5 clk = ~clk;

    int unsigned n_checks = 0;
    int unsigned n_fail = 0;

    // Model: selector 0 is the image store, 1..5 the layer banks.
    logic [19:0] mem_m [8][4096];
    logic [19:0] exp_cd = '0;
    logic [1:0]  exp_err = '0;

    task automatic check_eq(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        if (obs !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", tag, obs, exp, $time);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    function automatic int bank_depth(input int sel);
        case (sel)
            0, 1, 2: return 4096;
            3, 4:    return 1024;
            5:       return 2048;
            default: return 0;
        endcase
    endfunction

    function automatic logic [19:0] store_read(input int sel, input int addr);
        int d;
        d = bank_depth(sel);
        if (d == 0) return 20'd0;
`ifdef CMEM_BOUNDS_CHK_EN
        if (addr >= d) return 20'd0;
`endif
        return mem_m[sel][addr % d];
    endfunction

    function automatic logic [19:0] layer_read(input int sel, input int addr);
        if (sel < 1 || sel > 5) return 20'd0;
        return store_read(sel, addr);
    endfunction

    task automatic model_write(input int sel, input int addr, input logic [19:0] d);
        int dep;
        dep = bank_depth(sel);
        if (sel < 1 || sel > 5) return;
`ifdef CMEM_BOUNDS_CHK_EN
        if (addr >= dep) return;
`endif
        mem_m[sel][addr % dep] = d;
    endtask

    // One RUN cycle of layer traffic plus an image fetch, checked one edge later.
    task automatic layer_op(input bit wr, input bit rd, input int sel, input int wa, input int ra,
                            input logic [19:0] d, input int ia);
        cwr      = wr;
        crd      = rd;
        csel     = 3'(sel);
        caddr_wr = 12'(wa);
        caddr_rd = 12'(ra);
        cdata_wr = d;
        iaddr    = 12'(ia);
        if (rd) exp_cd = layer_read(sel, ra);
        if ((wr || rd) && (sel < 1 || sel > 5)) exp_err[0] = 1'b1;
`ifdef CMEM_BOUNDS_CHK_EN
        if (sel >= 1 && sel <= 5 &&
            ((wr && wa >= bank_depth(sel)) || (rd && ra >= bank_depth(sel)))) begin
            exp_err[1] = 1'b1;
        end
`endif
        if (wr) model_write(sel, wa, d);
        tick();
        cwr = 1'b0;
        crd = 1'b0;
        check_eq("cdata_rd", 32'(cdata_rd), 32'(exp_cd));
        check_eq("idata", 32'(idata), 32'(mem_m[0][ia]));
    endtask

    task automatic readback(input int sel, input int addr);
        rb_sel  = 3'(sel);
        rb_addr = 12'(addr);
        tick();
        check_eq("rb_data", 32'(rb_data), 32'(store_read(sel, addr)));
    endtask

    initial begin
        int s, a, wa, ra;
        bit w, r;

        // Reset values
        repeat (3) tick();
        check_eq("rst_ready", 32'(ready), 32'd0);
        check_eq("rst_done", 32'(done), 32'd0);
        check_eq("rst_err", 32'(err), 32'd0);
        check_eq("rst_idata", 32'(idata), 32'd0);
        check_eq("rst_cdata", 32'(cdata_rd), 32'd0);
        check_eq("rst_rb", 32'(rb_data), 32'd0);
        reset = 1'b1;
        tick();

        // Image load in IDLE
        for (int i = 0; i < 4096; i++) begin
            img_we    = 1'b1;
            img_addr  = 12'(i);
            img_wdata = 20'(i * 3);
            mem_m[0][i] = 20'(i * 3);
            tick();
        end
        img_we = 1'b0;
        for (int i = 0; i < 8; i++) readback(0, int'($urandom_range(0, 4095)));

        // Reset while in RDY
        start = 1'b1;
        tick();
        start = 1'b0;
        check_eq("rdy_ready", 32'(ready), 32'd1);
        #2 reset = 1'b0;
        #1 check_eq("async_ready", 32'(ready), 32'd0);
        for (int i = 0; i < 3; i++) begin
            tick();
            check_eq("rst_hold_done", 32'(done), 32'd0);
            check_eq("rst_hold_err", 32'(err), 32'd0);
        end
        reset = 1'b1;
        tick();
        check_eq("post_rst_ready", 32'(ready), 32'd0);
        readback(0, 1234);

        // Handshake timing: start at k, busy at k+3, busy drop at k+20
        start = 1'b1;
        tick();
        start = 1'b0;
        check_eq("hs_ready_k1", 32'(ready), 32'd1);
        tick();
        check_eq("hs_ready_k2", 32'(ready), 32'd1);
        tick();
        check_eq("hs_ready_k3", 32'(ready), 32'd1);
        busy = 1'b1;
        tick();
        check_eq("hs_ready_low", 32'(ready), 32'd0);
        repeat (16) tick();
        busy = 1'b0;
        tick();
        check_eq("hs_done_n", 32'(done), 32'd0);
        tick();
        check_eq("hs_done_n1", 32'(done), 32'd1);
        tick();
        check_eq("hs_done_n2", 32'(done), 32'd0);
        check_eq("hs_idle_ready", 32'(ready), 32'd0);

        // Main run
        start = 1'b1;
        tick();
        start = 1'b0;
        busy = 1'b1;
        tick();
        check_eq("run_ready", 32'(ready), 32'd0);

        // Fill every bank; bank 1 fill also sweeps the whole image.
        for (int sel = 1; sel <= 5; sel++) begin
            for (int i = 0; i < bank_depth(sel); i++) begin
                layer_op(1'b1, 1'b0, sel, i, 0, 20'($urandom),
                         (sel == 1) ? i : int'($urandom_range(0, 4095)));
            end
        end

        // Same address in two banks
        layer_op(1'b1, 1'b0, 1, 7, 0, 20'h12345, 11);
        layer_op(1'b1, 1'b0, 2, 7, 0, 20'hABCDE, 12);
        layer_op(1'b0, 1'b1, 1, 0, 7, 20'h0, 13);
        check_eq("bank1_a7", 32'(cdata_rd), 32'h12345);
        layer_op(1'b0, 1'b1, 2, 0, 7, 20'h0, 14);
        check_eq("bank2_a7", 32'(cdata_rd), 32'hABCDE);

        // Read-before-write collision
        layer_op(1'b1, 1'b0, 3, 10, 0, 20'h00001, 15);
        layer_op(1'b1, 1'b1, 3, 10, 10, 20'h00002, 16);
        check_eq("collide_old", 32'(cdata_rd), 32'h00001);
        layer_op(1'b0, 1'b1, 3, 0, 10, 20'h0, 17);
        check_eq("collide_new", 32'(cdata_rd), 32'h00002);

        // Random traffic in range
        for (int i = 0; i < 300; i++) begin
            s  = int'($urandom_range(1, 5));
            wa = int'($urandom_range(0, bank_depth(s) - 1));
            ra = ($urandom_range(0, 3) == 0) ? wa : int'($urandom_range(0, bank_depth(s) - 1));
            w  = 1'($urandom);
            r  = 1'($urandom);
            layer_op(w, r, s, wa, ra, 20'($urandom), int'($urandom_range(0, 4095)));
        end
        check_eq("err_clean", 32'(err), 32'(exp_err));

        // Invalid csel: write dropped, read returns zero, err[0]
        layer_op(1'b1, 1'b0, 6, 5, 0, 20'h55555, 1);
        check_eq("err_csel", 32'(err), 32'(exp_err));
        for (int sel = 1; sel <= 5; sel++) layer_op(1'b0, 1'b1, sel, 0, 5, 20'h0, 2);
        layer_op(1'b0, 1'b1, 7, 0, 9, 20'h0, 3);

        // Address 1024 into a 1024-deep bank
        layer_op(1'b1, 1'b0, 3, 1024, 0, 20'hFFFFF, 4);
        check_eq("err_oob", 32'(err), 32'(exp_err));
        layer_op(1'b0, 1'b1, 3, 0, 0, 20'h0, 5);

        // End of run
        busy = 1'b0;
        tick();
        check_eq("run_done_n", 32'(done), 32'd0);
        tick();
        check_eq("run_done_n1", 32'(done), 32'd1);
        tick();
        check_eq("run_done_n2", 32'(done), 32'd0);
        iaddr = 12'd100;
        tick();
        check_eq("idle_idata", 32'(idata), 32'd0);
        check_eq("err_sticky", 32'(err), 32'(exp_err));

        // Host readback of results
        readback(1, 7);
        readback(2, 7);
        for (int i = 0; i < 40; i++) begin
            s = int'($urandom_range(0, 7));
            a = (bank_depth(s) > 0) ? int'($urandom_range(0, bank_depth(s) - 1))
                                    : int'($urandom_range(0, 4095));
            readback(s, a);
        end

        // start clears err
        start = 1'b1;
        tick();
        start = 1'b0;
        exp_err = '0;
        check_eq("err_clear", 32'(err), 32'(exp_err));
        check_eq("run3_ready", 32'(ready), 32'd1);
        reset = 1'b0;
        tick();
        reset = 1'b1;
        tick();

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
